// File: rtl/input_wrapper_gen.sv
// input_wrapper_gen: gathers producer words into a frame bus, then runs a start/done handshake with the downstream core.
module input_wrapper_gen #(
    parameter int DATA_W = 8,
    parameter int NWORDS = 4,
    parameter int CNT_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [CNT_W-1:0]         frame_len,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     data_ready,
    output logic                     data_accepted,
    input  logic                     core_done,
    input  logic                     core_empty,
    output logic                     start,
    output logic [NWORDS*DATA_W-1:0] bus_out,
    output logic                     bus_valid,
    output logic [CNT_W-1:0]         word_cnt,
    output logic                     busy,
    output logic [7:0]               frame_cnt
);
    typedef enum logic [2:0] {
        IDLE, WAIT_DATA, CAPTURE, ACCEPT, ADVANCE, WAIT_CORE, START, RUN
    } state_t;

    localparam logic [CNT_W-1:0] NW = CNT_W'(NWORDS);

    state_t           state, state_nx;
    logic [CNT_W-1:0] len_r, eff_len, cnt_inc;

    // zero or oversized lengths fall back to the full buffer depth
    assign eff_len = (frame_len == '0 || frame_len > NW) ? NW : frame_len;
    assign cnt_inc = word_cnt + CNT_W'(1);

    assign data_accepted = state == ACCEPT;
    assign start         = state == START;
    assign bus_valid     = state == WAIT_CORE || state == START || state == RUN;
    assign busy          = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = WAIT_DATA;
            WAIT_DATA: state_nx = data_ready ? CAPTURE : WAIT_DATA;
            CAPTURE:   state_nx = ACCEPT;
            ACCEPT:    state_nx = data_ready ? ACCEPT : ADVANCE;
            ADVANCE:   state_nx = (cnt_inc == len_r) ? WAIT_CORE : WAIT_DATA;
            WAIT_CORE: state_nx = (core_done && core_empty) ? START : WAIT_CORE;
            START:     state_nx = core_done ? START : RUN;
            RUN:       state_nx = core_done ? IDLE : RUN;
            default:   state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bus_out   <= '0;
            word_cnt  <= '0;
            frame_cnt <= '0;
            len_r     <= NW;
        end else begin
            state <= state_nx;
            // an aborted frame leaves nothing behind, so IDLE already shows an empty bus
            if (flush) begin
                bus_out  <= '0;
                word_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        len_r    <= eff_len;
                        word_cnt <= '0;
                        bus_out  <= '0;
                    end
                    CAPTURE: begin
                        for (int k = 0; k < NWORDS; k++)
                            if (word_cnt == CNT_W'(k)) bus_out[k*DATA_W +: DATA_W] <= data_in;
                    end
                    ADVANCE: word_cnt <= cnt_inc;
                    RUN:     if (core_done) frame_cnt <= frame_cnt + 8'd1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_input_wrapper_gen.sv
// tb_input_wrapper_gen: directed checks of framing, handshakes, flush, clamping, wrap and async reset.
module tb_input_wrapper_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [2:0]  frame_len = 3'd0;
    logic [7:0]  data_in = 8'd0;
    logic        data_ready = 1'b0;
    logic        data_accepted;
    logic        core_done = 1'b1;
    logic        core_empty = 1'b1;
    logic        start;
    logic [31:0] bus_out;
    logic        bus_valid;
    logic [2:0]  word_cnt;
    logic        busy;
    logic [7:0]  frame_cnt;
    int          tests = 0;
    int          fails = 0;
    int          lat;

    input_wrapper_gen dut (
        .clk(clk), .rst(rst), .flush(flush), .frame_len(frame_len),
        .data_in(data_in), .data_ready(data_ready), .data_accepted(data_accepted),
        .core_done(core_done), .core_empty(core_empty), .start(start),
        .bus_out(bus_out), .bus_valid(bus_valid), .word_cnt(word_cnt),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // called in WAIT_DATA; returns in WAIT_DATA or WAIT_CORE
    task automatic send_word(input logic [7:0] w, output int l);
        data_in = w;
        data_ready = 1'b1;
        l = 0;
        while (!data_accepted && l < 20) begin
            tick();
            l++;
        end
        check("accept", data_accepted, 1);
        data_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic new_frame(input logic [2:0] len);
        frame_len = len;
        tick();
    endtask

    task automatic finish_frame();
        core_done = 1'b1;
        core_empty = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        core_done = 1'b1;
        tick();
    endtask

    initial begin
        #2;
        check("rst_bus", bus_out, 0);
        check("rst_ctl", {busy, bus_valid, start, data_accepted}, 0);
        check("rst_cnt", {word_cnt, frame_cnt}, 0);
        #5 rst = 1'b0;
        tick();
        // full-length frame
        new_frame(3'd0);
        send_word(8'h11, lat);
        check("latency", lat, 2);
        check("advance_cnt", word_cnt, 1);
        send_word(8'h22, lat);
        send_word(8'h33, lat);
        check("not_valid_yet", bus_valid, 0);
        send_word(8'h44, lat);
        check("full_bus", bus_out, 32'h44332211);
        check("full_cnt", word_cnt, 4);
        check("full_valid", bus_valid, 1);
        tick();
        check("start_on", start, 1);
        core_done = 1'b0;
        tick();
        check("run_start_off", {start, bus_valid}, 2'b01);
        core_done = 1'b1;
        tick();
        check("frame_cnt1", frame_cnt, 1);
        check("idle_busy", busy, 0);
        // short frame with a length change mid-frame and a stalled core
        new_frame(3'd2);
        core_empty = 1'b0;
        send_word(8'hA5, lat);
        frame_len = 3'd4;
        send_word(8'h5A, lat);
        check("short_bus", bus_out, 32'h00005AA5);
        check("short_cnt", word_cnt, 2);
        check("short_valid", bus_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_hold", {start, bus_valid, bus_out}, {2'b01, 32'h00005AA5});
        end
        core_empty = 1'b1;
        tick();
        check("stall_release", start, 1);
        core_done = 1'b0;
        tick();
        core_done = 1'b1;
        tick();
        check("frame_cnt2", frame_cnt, 2);
        // flush during the fourth word's acceptance
        new_frame(3'd0);
        send_word(8'h01, lat);
        send_word(8'h02, lat);
        send_word(8'h03, lat);
        data_in = 8'h04;
        data_ready = 1'b1;
        lat = 0;
        while (!data_accepted && lat < 20) begin
            tick();
            lat++;
        end
        check("flush_in_accept", data_accepted, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_state", {busy, data_accepted, bus_valid, start}, 0);
        check("flush_bus", bus_out, 0);
        check("flush_cnt", {word_cnt, frame_cnt}, {3'd0, 8'd2});
        data_ready = 1'b0;
        tick();
        send_word(8'hA1, lat);
        send_word(8'hA2, lat);
        send_word(8'hA3, lat);
        send_word(8'hA4, lat);
        check("post_flush_bus", bus_out, 32'hA4A3A2A1);
        finish_frame();
        check("frame_cnt3", frame_cnt, 3);
        // oversized length clamps to the buffer depth
        new_frame(3'd7);
        send_word(8'hB1, lat);
        send_word(8'hB2, lat);
        send_word(8'hB3, lat);
        check("clamp_not_done", bus_valid, 0);
        send_word(8'hB4, lat);
        check("clamp_done", {bus_valid, word_cnt}, {1'b1, 3'd4});
        check("clamp_bus", bus_out, 32'hB4B3B2B1);
        finish_frame();
        check("frame_cnt4", frame_cnt, 4);
        // frame counter wrap
        for (int i = 0; i < 251; i++) begin
            new_frame(3'd1);
            send_word(i[7:0], lat);
            finish_frame();
        end
        check("frame_cnt255", frame_cnt, 255);
        new_frame(3'd1);
        send_word(8'h77, lat);
        check("len1_bus", bus_out, 32'h00000077);
        finish_frame();
        check("frame_cnt_wrap", frame_cnt, 0);
        // asynchronous reset while in RUN
        new_frame(3'd2);
        send_word(8'hD1, lat);
        send_word(8'hD2, lat);
        tick();
        core_done = 1'b0;
        tick();
        check("in_run", {bus_valid, start, busy}, 3'b101);
        #2 rst = 1'b1;
        #1;
        check("async_ctl", {busy, bus_valid, start, data_accepted}, 0);
        check("async_bus", bus_out, 0);
        check("async_cnt", {word_cnt, frame_cnt}, 0);
        core_done = 1'b1;
        tick();
        rst = 1'b0;
        new_frame(3'd2);
        send_word(8'hC1, lat);
        send_word(8'hC2, lat);
        check("post_rst_bus", bus_out, 32'h0000C2C1);
        check("post_rst_cnt", word_cnt, 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
